// File: rtl/zelda_sprite_pkg.sv
// ============================================================================
// zelda_sprite_pkg : shared types and defaults for the player sprite path
// Rev 1.0
// ============================================================================
`default_nettype none

package zelda_sprite_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int          SPRITE_W_DEF        = 16;
    localparam int          SPRITE_H_DEF        = 16;
    localparam logic [3:0]  TRANSPARENT_IDX_DEF = 4'h0;

endpackage

`default_nettype wire

// File: rtl/link_anim_ctrl.sv
// ============================================================================
// link_anim_ctrl : per-frame walk animation counter and frame toggle
// Rev 1.0
// ============================================================================
`default_nettype none

module link_anim_ctrl
    import zelda_sprite_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic vsync_pulse,
    input  logic moving,
    output logic frame
);

    localparam int               CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Standing still snaps back to the idle pose immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt   <= '0;
            frame <= 1'b0;
        end else if (vsync_pulse) begin
            if (moving) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    frame <= ~frame;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt   <= '0;
                frame <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/link_sprite_fetch.sv
// ============================================================================
// link_sprite_fetch : player box hit test and sprite ROM addressing, 3 stages
// Rev 1.0
// ============================================================================
`default_nettype none

module link_sprite_fetch
    import zelda_sprite_pkg::*;
#(
    parameter int         SPRITE_W        = SPRITE_W_DEF,
    parameter int         SPRITE_H        = SPRITE_H_DEF,
    parameter int         ANIM_DIV        = 8,
    parameter logic [3:0] TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
    parameter int         ADDR_W          = 3 + $clog2(SPRITE_W) + $clog2(SPRITE_H)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vsync_pulse,
    input  logic              pix_en,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        dir,
    input  logic              moving,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              opaque,
    output logic              out_valid
);

    localparam int LW = $clog2(SPRITE_W);
    localparam int LH = $clog2(SPRITE_H);

    logic [9:0]  sx;
    logic [9:0]  sy;
    dir_t        sdir;
    logic        frame;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        hit;
    logic        hit1;
    logic        hit2;
    logic        valid1;
    logic        valid2;

    link_anim_ctrl #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .vsync_pulse (vsync_pulse),
        .moving      (moving),
        .frame       (frame)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx   <= '0;
            sy   <= '0;
            sdir <= DIR_DOWN;
        end else if (vsync_pulse) begin
            sx   <= pos_x;
            sy   <= pos_y;
            sdir <= dir_t'(dir);
        end
    end

    // Explicit >= guards keep the box from wrapping past column/row 1023.
    assign dx  = {1'b0, draw_x} - {1'b0, sx};
    assign dy  = {1'b0, draw_y} - {1'b0, sy};
    assign hit = pix_en && (draw_x >= sx) && (draw_y >= sy)
                 && (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr <= '0;
            hit1     <= 1'b0;
            valid1   <= 1'b0;
            hit2     <= 1'b0;
            valid2   <= 1'b0;
        end else begin
            hit1   <= hit;
            valid1 <= pix_en;
            hit2   <= hit1;
            valid2 <= valid1;
            if (hit) begin
                rom_addr <= {sdir, frame, dy[LH-1:0], dx[LW-1:0]};
            end
        end
    end

    // Stage 3 lines up with the ROM's registered output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            index     <= TRANSPARENT_IDX;
            opaque    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid2;
            index     <= hit2 ? rom_data : TRANSPARENT_IDX;
            opaque    <= hit2 && (rom_data != TRANSPARENT_IDX);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_link_sprite_fetch.sv
// ============================================================================
// tb_link_sprite_fetch : directed + random bench with a box/ROM reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_link_sprite_fetch;
    import zelda_sprite_pkg::*;

    localparam int         W   = 16;
    localparam int         H   = 16;
    localparam int         DIV = 8;
    localparam int         LW  = 4;
    localparam int         LH  = 4;
    localparam logic [3:0] T   = 4'h0;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        vsync_pulse, pix_en, moving;
    logic [9:0]  draw_x, draw_y, pos_x, pos_y;
    logic [1:0]  dir;
    logic [10:0] rom_addr;
    logic [3:0]  rom_data = 4'h0;
    logic [3:0]  index;
    logic        opaque, out_valid;

    logic [3:0]  rom_mem [0:2047];

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         valid;
        logic [3:0] idx;
        bit         opq;
    } exp_t;
    exp_t q[$];

    int m_sx, m_sy, m_dir, m_run;

    link_sprite_fetch #(
        .SPRITE_W (W), .SPRITE_H (H), .ANIM_DIV (DIV), .TRANSPARENT_IDX (T)
    ) dut (
        .Clk (Clk), .Reset_n (Reset_n), .vsync_pulse (vsync_pulse), .pix_en (pix_en),
        .draw_x (draw_x), .draw_y (draw_y), .pos_x (pos_x), .pos_y (pos_y),
        .dir (dir), .moving (moving), .rom_addr (rom_addr), .rom_data (rom_data),
        .index (index), .opaque (opaque), .out_valid (out_valid)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_frame();
        return (m_run / DIV) % 2;
    endfunction

    function automatic bit m_hit(input bit pe, input int x, input int y);
        return pe && x >= m_sx && x < m_sx + W && y >= m_sy && y < m_sy + H;
    endfunction

    function automatic int m_addr(input int x, input int y);
        return m_dir * (1 << (1 + LH + LW)) + m_frame() * (1 << (LH + LW))
               + (y - m_sy) * W + (x - m_sx);
    endfunction

    task automatic model_reset();
        exp_t idle;
        idle.valid = 1'b0; idle.idx = T; idle.opq = 1'b0;
        m_sx = 0; m_sy = 0; m_dir = 0; m_run = 0;
        q.delete();
        q.push_back(idle);
        q.push_back(idle);
    endtask

    task automatic step(input bit vs, input bit pe, input int x, input int y);
        exp_t e, o;
        bit   h;
        int   a;
        vsync_pulse = vs; pix_en = pe;
        draw_x = 10'(x); draw_y = 10'(y);
        h = m_hit(pe, x, y);
        a = h ? m_addr(x, y) : 0;
        e.valid = pe;
        e.idx   = h ? rom_mem[a] : T;
        e.opq   = h && (rom_mem[a] != T);
        q.push_back(e);
        if (vs) begin
            m_sx = pos_x; m_sy = pos_y; m_dir = dir;
            if (moving) m_run++; else m_run = 0;
        end
        @(posedge Clk); #1;
        o = q.pop_front();
        check("out_valid", out_valid, o.valid);
        check("index", index, o.idx);
        check("opaque", opaque, o.opq);
        if (h) check("rom_addr", rom_addr, a);
        vsync_pulse = 1'b0; pix_en = 1'b0;
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    endtask

    task automatic set_pos(input int x, input int y, input int d, input bit mv);
        pos_x = 10'(x); pos_y = 10'(y); dir = 2'(d); moving = mv;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        Reset_n = 1'b0; vsync_pulse = 0; pix_en = 0; moving = 0;
        draw_x = '0; draw_y = '0; pos_x = '0; pos_y = '0; dir = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_index", index, T);
        check("rst_opaque", opaque, 0);
        check("rst_rom_addr", rom_addr, 0);
        Reset_n = 1'b1;
        model_reset();

        // Basic hit and address layout
        set_pos(100, 50, 2, 0);
        step(1, 0, 0, 0);
        step(0, 1, 103, 55);
        check("addr_const", rom_addr, 11'b10_0_0101_0011);
        flush();

        // Box edges and no wrap-around
        step(0, 1, 99, 50);  step(0, 1, 100, 50); step(0, 1, 115, 50); step(0, 1, 116, 50);
        step(0, 1, 100, 49); step(0, 1, 100, 65); step(0, 1, 100, 66);
        flush();
        set_pos(1020, 50, 3, 0);
        step(1, 0, 0, 0);
        step(0, 1, 2, 50); step(0, 1, 1021, 50); step(0, 1, 1023, 60); step(0, 1, 3, 51);
        flush();

        // Snapshot holds mid-frame; simultaneous vsync uses old position
        set_pos(200, 100, 1, 0);
        step(1, 0, 0, 0);
        step(0, 1, 205, 100);
        pos_x = 10'd300;
        step(0, 1, 205, 101); step(0, 1, 215, 115);
        step(1, 1, 205, 100);
        step(0, 1, 205, 100); step(0, 1, 305, 100);
        flush();

        // Walk animation, stop at pulse 11, then walk through two toggles
        set_pos(100, 50, 1, 1);
        for (int p = 1; p <= 28; p++) begin
            moving = (p != 11);
            step(1, 0, 0, 0);
            check("anim_cnt", dut.u_anim.cnt, m_run % DIV);
            step(0, 1, 100 + (p % 16), 50 + (p % 7));
        end
        flush();

        // Transparent and opaque ROM words inside the box
        set_pos(100, 50, 2, 0);
        step(1, 0, 0, 0);
        flush();
        rom_mem[m_addr(104, 52)] = T;
        rom_mem[m_addr(105, 52)] = 4'h3;
        step(0, 1, 104, 52); step(0, 1, 105, 52);
        flush();

        // Random pixels around randomly placed boxes
        for (int blk = 0; blk < 6; blk++) begin
            int px, py;
            px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
            set_pos(px, py, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            step(1, 0, 0, 0);
            for (int i = 0; i < 50; i++) begin
                int x, y;
                x = (px + 1024 - 4 + $urandom_range(0, 24)) % 1024;
                y = (py + 1024 - 4 + $urandom_range(0, 24)) % 1024;
                step(0, ($urandom_range(0, 3) != 0), x, y);
            end
        end
        flush();

        // Reset with pixels in flight
        set_pos(100, 50, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 101, 51); step(0, 1, 102, 51); step(0, 1, 103, 51);
        #2;
        Reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_index", index, T);
        check("midrst_opaque", opaque, 0);
        check("midrst_rom_addr", rom_addr, 0);
        check("midrst_cnt", dut.u_anim.cnt, 0);
        @(posedge Clk); #3;
        Reset_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0);
        step(0, 1, 3, 4);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/link_sprite_fetch.md
# link_sprite_fetch

Per-pixel sprite fetch stage for the player character. It sits directly upstream of the palette lookup: it tests each VGA pixel against the player's box and generates the sprite ROM address. The address selects direction, animation frame and in-sprite offset. It returns a registered 4-bit palette index plus an opaque flag, which feed the palette module and the compositor. Player position, direction and motion are snapshotted once per video frame, so the sprite never tears mid-scan.

## Interface
Parameters:
- SPRITE_W, 16, sprite width in pixels (power of two)
- SPRITE_H, 16, sprite height in pixels (power of two)
- ANIM_DIV, 8, video frames per animation step (≥1)
- TRANSPARENT_IDX, 4'h0, palette index treated as transparent
- ADDR_W, 3+log2(SPRITE_W)+log2(SPRITE_H), ROM address width (derived, 11 at defaults)

Ports:
- Clk  in  1  pixel-domain clock
- Reset_n  in  1  asynchronous, active-low reset
- vsync_pulse  in  1  one-cycle start-of-frame strobe
- pix_en  in  1  draw_x/draw_y valid this cycle
- draw_x  in  10  current pixel column
- draw_y  in  10  current pixel row
- pos_x  in  10  player top-left column (live game state)
- pos_y  in  10  player top-left row
- dir  in  2  facing direction (dir_t)
- moving  in  1  player walking this frame
- rom_addr  out  ADDR_W  address to synchronous sprite ROM (1-cycle read latency)
- rom_data  in  4  palette index from ROM
- index  out  4  palette index to palette stage
- opaque  out  1  pixel is inside the sprite and non-transparent
- out_valid  out  1  index/opaque correspond to a valid pixel

## Operation
- Snapshot registers (sx, sy, sdir) load pos_x, pos_y and dir on vsync_pulse. They hold for the rest of the frame.
- Animation (link_anim_ctrl), on vsync_pulse only:
  - moving=1: cnt increments. When cnt == ANIM_DIV-1, cnt wraps to 0 and frame toggles.
  - moving=0: cnt←0 and frame←0.
  - No change without vsync_pulse.
- Hit test, using snapshot and frame values from before the current edge:
  - dx = draw_x − sx and dy = draw_y − sy, computed in 11 bits.
  - hit = pix_en ∧ draw_x ≥ sx ∧ draw_y ≥ sy ∧ dx < SPRITE_W ∧ dy < SPRITE_H.
  - There is no wrap-around: sx=1020 with draw_x=2 is not a hit.
- Address: rom_addr = {sdir, frame, dy[log2 H−1:0], dx[log2 W−1:0]}.
  - On a non-hit, rom_addr holds its previous value; the value is don't-care.
- Output stage:
  - index = rom_data when the pipelined hit is set, else TRANSPARENT_IDX.
  - opaque = pipelined hit ∧ rom_data ≠ TRANSPARENT_IDX.
  - out_valid = pipelined pix_en.
  - When out_valid=0: opaque=0 and index=TRANSPARENT_IDX.
- vsync_pulse and pix_en in the same cycle: that pixel uses the old snapshot and frame. New values apply from the next cycle.

## Timing
- Three-stage pipeline. Inputs sampled at edge k produce:
  - rom_addr, hit and valid registers at edge k (stage 1);
  - ROM data registered inside the ROM at edge k+1 (stage 2);
  - index, opaque and out_valid registered at edge k+2, visible after that edge.
- Latency is 3 cycles from input presentation to output; throughput is one pixel per cycle with no stalls.
- Reset (async, Reset_n=0) sets every register to 0:
  - sx, sy, sdir, cnt, frame, rom_addr, out_valid, opaque = 0;
  - index = TRANSPARENT_IDX.
- Reset asserted mid-line: in-flight pixels are dropped and out_valid falls immediately. After release, the first out_valid=1 occurs 3 cycles after the first pix_en.
- ANIM_DIV=1: frame toggles on every vsync_pulse while moving.

## Structure
- Package zelda_sprite_pkg holds:
  - typedef enum logic [1:0] dir_t {DIR_DOWN=0, DIR_UP=1, DIR_LEFT=2, DIR_RIGHT=3};
  - constants SPRITE_W_DEF, SPRITE_H_DEF and TRANSPARENT_IDX_DEF.
- Sub-module link_anim_ctrl holds the vsync counter and frame toggle.
  - Ports: Clk, Reset_n, vsync_pulse, moving, frame.
  - Parameter: ANIM_DIV.
- The sprite ROM stays external, with one generated ROM per sprite sheet.

## Test plan
- Hit/address: vsync with pos=(100,50), dir=LEFT(2), moving=0; then draw (103,55) with pix_en → rom_addr=11'b10_0_0101_0011 after 1 edge. Index equals the ROM word and out_valid=1 after 3 edges.
- Boundaries: same snapshot with draw_x = 99, 100, 115, 116 on row 50 → hit only at 100 and 115. Also pos_x=1020, draw_x=2 → no hit, opaque=0, index=TRANSPARENT_IDX.
- Animation: moving=1, ANIM_DIV=8 → frame toggles on the 8th, 16th, … vsync pulses. Drop moving at pulse 11 → frame=0 and cnt=0 after that pulse.
- Tearing: change pos_x mid-frame without vsync → addresses unchanged. Assert vsync and pix_en together → that pixel uses the old position, the next uses the new.
- Transparency: ROM returns TRANSPARENT_IDX inside the box → opaque=0, out_valid=1. ROM returns 4'h3 → opaque=1, index=3.
- Reset: assert Reset_n=0 with 3 pixels in flight → out_valid=0 at once and all outputs at reset values. Release, then pix_en → first out_valid exactly 3 cycles later.
